// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA request arbiter.
package dma_arb_pkg;

    localparam int CL_DATA_WIDTH           = 512;
    localparam int VIRTUAL_BYTE_ADDR_WIDTH = 64;

    typedef logic [32:0] count_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_RD_BEAT,
        S_RD_WAIT,
        S_WR_BEAT,
        S_WR_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_pick
    import dma_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    localparam int unsigned NU = N;

    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = ID_W'((32'(ptr) + i) % NU);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant[idx] = 1'b1;
                grant_id  = idx;
            end
        end
    end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing one single-line DMA read/write channel between NUM_REQ requesters.
module dma_req_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = VIRTUAL_BYTE_ADDR_WIDTH,
    parameter int DATA_WIDTH   = CL_DATA_WIDTH,
    parameter int SIZE_WIDTH   = 33,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [ADDR_WIDTH-1:0]         dma_rd_addr,
    output logic [ADDR_WIDTH-1:0]         dma_wr_addr,
    output logic [SIZE_WIDTH-1:0]         dma_rd_size,
    output logic [SIZE_WIDTH-1:0]         dma_wr_size,
    output logic                          dma_rd_go,
    output logic                          dma_wr_go,
    output logic                          dma_rd_en,
    output logic                          dma_wr_en,
    input  logic [DATA_WIDTH-1:0]         dma_rd_data,
    output logic [DATA_WIDTH-1:0]         dma_wr_data,
    input  logic                          dma_empty,
    input  logic                          dma_full,
    input  logic                          dma_rd_done,
    input  logic                          dma_wr_done
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                  state_q;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         id_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [12:0]             wait_q;
    logic                    busy_q;
    logic                    rd_go_q;
    logic                    wr_go_q;
    logic [NUM_REQ-1:0]      resp_q;
    logic                    tmo_q;

    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         win_id;
    logic                    win_any;
    logic                    done_seen;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (win_id),
        .any      (win_any)
    );

    always_comb begin
        done_seen = (state_q == S_RD_WAIT) ? dma_rd_done : dma_wr_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            rd_go_q  <= 1'b0;
            wr_go_q  <= 1'b0;
            resp_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            rd_go_q <= 1'b0;
            wr_go_q <= 1'b0;
            resp_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_any) begin
                        id_q    <= win_id;
                        write_q <= req_write[win_id];
                        addr_q  <= addr_arr[win_id];
                        wdata_q <= wdata_arr[win_id];
                        rd_go_q <= !req_write[win_id];
                        wr_go_q <= req_write[win_id];
                        busy_q  <= 1'b1;
                        state_q <= S_GO;
                    end
                end
                S_GO: state_q <= write_q ? S_WR_BEAT : S_RD_BEAT;
                S_RD_BEAT: begin
                    if (!dma_empty) begin
                        rdata_q <= dma_rd_data;
                        wait_q  <= '0;
                        state_q <= S_RD_WAIT;
                    end
                end
                S_WR_BEAT: begin
                    if (!dma_full) begin
                        wait_q  <= '0;
                        state_q <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    // A hung transfer still completes (flagged) so other requesters are not starved.
                    if (done_seen) begin
                        resp_q  <= NUM_REQ'(1) << id_q;
                        state_q <= S_RESP;
                    end else if (wait_q == 13'(DONE_TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        resp_q  <= NUM_REQ'(1) << id_q;
                        state_q <= S_RESP;
                    end else begin
                        wait_q <= wait_q + 13'd1;
                    end
                end
                S_RESP: begin
                    rr_ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE) ? grant : '0;
    assign resp_valid  = resp_q;
    assign resp_rdata  = rdata_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;
    assign dma_rd_addr = addr_q;
    assign dma_wr_addr = addr_q;
    assign dma_rd_size = SIZE_WIDTH'(1);
    assign dma_wr_size = SIZE_WIDTH'(1);
    assign dma_rd_go   = rd_go_q;
    assign dma_wr_go   = wr_go_q;
    assign dma_rd_en   = (state_q == S_RD_BEAT) && !dma_empty;
    assign dma_wr_en   = (state_q == S_WR_BEAT) && !dma_full;
    assign dma_wr_data = wdata_q;

    a_one_dma_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}));

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed self-checking bench for dma_req_arbiter (2 requesters, DONE_TIMEOUT=16).
module tb_dma_req_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int SW  = 33;
    localparam int TMO = 16;

    localparam logic [DW-1:0] LINE1 = {16{32'hC0DE_0001}};
    localparam logic [DW-1:0] LINE2 = {16{32'h1234_5678}};
    localparam logic [DW-1:0] LINE3 = {16{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] WPAT  = {64{8'hA5}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              busy;
    logic              timeout_err;
    logic [AW-1:0]     dma_rd_addr;
    logic [AW-1:0]     dma_wr_addr;
    logic [SW-1:0]     dma_rd_size;
    logic [SW-1:0]     dma_wr_size;
    logic              dma_rd_go;
    logic              dma_wr_go;
    logic              dma_rd_en;
    logic              dma_wr_en;
    logic [DW-1:0]     dma_rd_data = '0;
    logic [DW-1:0]     dma_wr_data;
    logic              dma_empty = 1'b1;
    logic              dma_full = 1'b1;
    logic              dma_rd_done = 1'b0;
    logic              dma_wr_done = 1'b0;

    int chk = 0;
    int pass = 0;
    int n_rd_go = 0;
    int n_rd_en = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dma_rd_go) n_rd_go <= n_rd_go + 1;
        if (dma_rd_en) n_rd_en <= n_rd_en + 1;
    end

    dma_req_arbiter #(
        .NUM_REQ      (NR),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .SIZE_WIDTH   (SW),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dma_rd_addr (dma_rd_addr),
        .dma_wr_addr (dma_wr_addr),
        .dma_rd_size (dma_rd_size),
        .dma_wr_size (dma_wr_size),
        .dma_rd_go   (dma_rd_go),
        .dma_wr_go   (dma_wr_go),
        .dma_rd_en   (dma_rd_en),
        .dma_wr_en   (dma_wr_en),
        .dma_rd_data (dma_rd_data),
        .dma_wr_data (dma_wr_data),
        .dma_empty   (dma_empty),
        .dma_full    (dma_full),
        .dma_rd_done (dma_rd_done),
        .dma_wr_done (dma_wr_done)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
        chk++; if (timeout_err !== 1'b0) $display("FAIL reset_tmo got=%b exp=0", timeout_err); else pass++;
        chk++; if ({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en} !== 4'b0000) $display("FAIL reset_strobes got=%b exp=0000", {dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}); else pass++;
        chk++; if ({req_ready, resp_valid} !== 4'b0000) $display("FAIL reset_handshake got=%b exp=0000", {req_ready, resp_valid}); else pass++;
        chk++; if (resp_rdata !== {DW{1'b0}}) $display("FAIL reset_rdata got=%h exp=0", resp_rdata); else pass++;
        chk++; if ({dma_rd_addr, dma_wr_addr} !== {2*AW{1'b0}} || dma_wr_data !== {DW{1'b0}}) $display("FAIL reset_latches got=%h/%h exp=0", dma_rd_addr, dma_wr_addr); else pass++;
        chk++; if (dma_rd_size !== 33'd1 || dma_wr_size !== 33'd1) $display("FAIL reset_size got=%0d/%0d exp=1", dma_rd_size, dma_wr_size); else pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int g0;
        int e0;
        g0 = n_rd_go;
        e0 = n_rd_en;
        req_valid = 2'b01; req_write = 2'b00; req_addr[63:0] = 64'h1000;
        #1;
        chk++; if (req_ready !== 2'b01) $display("FAIL rd_ready got=%b exp=01", req_ready); else pass++;
        tick(); req_valid = 2'b00; #1;
        chk++; if (dma_rd_go !== 1'b1 || dma_wr_go !== 1'b0) $display("FAIL rd_go got=%b%b exp=10", dma_rd_go, dma_wr_go); else pass++;
        chk++; if (dma_rd_addr !== 64'h1000 || dma_rd_size !== 33'd1) $display("FAIL rd_addr got=%h/%0d exp=1000/1", dma_rd_addr, dma_rd_size); else pass++;
        tick(); tick(); #1;
        chk++; if (dma_rd_en !== 1'b0) $display("FAIL rd_en_stall got=%b exp=0", dma_rd_en); else pass++;
        tick(); dma_empty = 1'b0; dma_rd_data = LINE1; #1;
        chk++; if (dma_rd_en !== 1'b1) $display("FAIL rd_en_fire got=%b exp=1", dma_rd_en); else pass++;
        tick(); dma_empty = 1'b1; dma_rd_data = '0;
        tick(); dma_rd_done = 1'b1; #1;
        chk++; if (resp_valid !== 2'b00) $display("FAIL rd_resp_early got=%b exp=00", resp_valid); else pass++;
        tick(); dma_rd_done = 1'b0; #1;
        chk++; if (resp_valid !== 2'b01) $display("FAIL rd_resp got=%b exp=01", resp_valid); else pass++;
        chk++; if (resp_rdata !== LINE1) $display("FAIL rd_rdata got=%h exp=%h", resp_rdata, LINE1); else pass++;
        chk++; if (n_rd_go - g0 != 1 || n_rd_en - e0 != 1) $display("FAIL rd_pulses got=%0d/%0d exp=1/1", n_rd_go - g0, n_rd_en - e0); else pass++;
        tick(); #1;
        chk++; if (busy !== 1'b0 || resp_valid !== 2'b00) $display("FAIL rd_idle got=%b/%b exp=0/00", busy, resp_valid); else pass++;
    endtask

    task automatic test_single_write();
        req_valid = 2'b10; req_write = 2'b10; req_addr[127:64] = 64'h2040; req_wdata[1023:512] = WPAT;
        #1;
        chk++; if (req_ready !== 2'b10) $display("FAIL wr_ready got=%b exp=10", req_ready); else pass++;
        tick(); req_valid = 2'b00; #1;
        chk++; if (dma_wr_go !== 1'b1 || dma_rd_go !== 1'b0) $display("FAIL wr_go got=%b%b exp=10", dma_wr_go, dma_rd_go); else pass++;
        chk++; if (dma_wr_addr !== 64'h2040 || dma_wr_size !== 33'd1) $display("FAIL wr_addr got=%h/%0d exp=2040/1", dma_wr_addr, dma_wr_size); else pass++;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk++; if (dma_wr_en !== 1'b0 || dma_wr_data !== WPAT) $display("FAIL wr_stall%0d got=%b exp=0", i, dma_wr_en); else pass++;
        end
        tick(); dma_full = 1'b0; #1;
        chk++; if (dma_wr_en !== 1'b1 || dma_wr_data !== WPAT) $display("FAIL wr_en_fire got=%b data=%h exp=1", dma_wr_en, dma_wr_data); else pass++;
        tick(); dma_full = 1'b1; dma_wr_done = 1'b1; #1;
        chk++; if (resp_valid !== 2'b00) $display("FAIL wr_resp_early got=%b exp=00", resp_valid); else pass++;
        tick(); dma_wr_done = 1'b0; #1;
        chk++; if (resp_valid !== 2'b10) $display("FAIL wr_resp got=%b exp=10", resp_valid); else pass++;
        chk++; if (resp_rdata !== LINE1) $display("FAIL wr_rdata_held got=%h exp=%h", resp_rdata, LINE1); else pass++;
        tick();
    endtask

    task automatic test_contention();
        req_valid = 2'b11; req_write = 2'b10;
        req_addr = {64'h200, 64'h100};
        dma_empty = 1'b0; dma_full = 1'b0; dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        dma_rd_data = LINE2;
        for (int t = 0; t < 4; t++) begin
            int n = 0;
            logic [1:0] exp_g;
            logic [1:0] got_g;
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
            got_g = req_ready;
            chk++; if (got_g !== exp_g) $display("FAIL cont_grant%0d got=%b exp=%b", t, got_g, exp_g); else pass++;
            tick(); #1;
            chk++; if (req_ready !== 2'b00) $display("FAIL cont_busy_ignore%0d got=%b exp=00", t, req_ready); else pass++;
            n = 0;
            while (resp_valid == 2'b00 && n < 20) begin tick(); n++; end
            chk++; if (resp_valid !== exp_g) $display("FAIL cont_resp%0d got=%b exp=%b", t, resp_valid, exp_g); else pass++;
        end
        req_valid = 2'b00; dma_empty = 1'b1; dma_full = 1'b1; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        req_valid = 2'b01; req_write = 2'b00; req_addr[63:0] = 64'h4000; dma_rd_data = LINE3;
        #1;
        chk++; if (req_ready !== 2'b01) $display("FAIL tmo_ready got=%b exp=01", req_ready); else pass++;
        tick(); req_valid = 2'b00;
        tick(); dma_empty = 1'b0;
        tick(); dma_empty = 1'b1; #1;
        chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_early got=%b exp=0", timeout_err); else pass++;
        n = 0;
        while (resp_valid == 2'b00 && n < 40) begin tick(); n++; end
        chk++; if (n != TMO) $display("FAIL tmo_cycles got=%0d exp=%0d", n, TMO); else pass++;
        chk++; if (timeout_err !== 1'b1 || resp_valid !== 2'b01) $display("FAIL tmo_resp got=%b/%b exp=1/01", timeout_err, resp_valid); else pass++;
        chk++; if (resp_rdata !== LINE3) $display("FAIL tmo_rdata got=%h exp=%h", resp_rdata, LINE3); else pass++;
        tick(); #1;
        chk++; if (timeout_err !== 1'b1 || busy !== 1'b0) $display("FAIL tmo_sticky got=%b/%b exp=1/0", timeout_err, busy); else pass++;
        req_valid = 2'b10; req_write = 2'b10; req_addr[127:64] = 64'h5000;
        dma_full = 1'b0; dma_wr_done = 1'b1;
        #1;
        chk++; if (req_ready !== 2'b10) $display("FAIL tmo_next_ready got=%b exp=10", req_ready); else pass++;
        tick(); req_valid = 2'b00; n = 1;
        while (resp_valid == 2'b00 && n < 20) begin tick(); n++; end
        chk++; if (n != 4 || resp_valid !== 2'b10) $display("FAIL tmo_next_resp got=%0d/%b exp=4/10", n, resp_valid); else pass++;
        chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_still_set got=%b exp=1", timeout_err); else pass++;
        dma_full = 1'b1; dma_wr_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        req_valid = 2'b10; req_write = 2'b10; req_addr[127:64] = 64'h6000;
        #1;
        chk++; if (req_ready !== 2'b10) $display("FAIL rst_mid_ready got=%b exp=10", req_ready); else pass++;
        tick(); req_valid = 2'b00;
        tick(); #1;
        chk++; if (dma_wr_en !== 1'b0) $display("FAIL rst_mid_stall got=%b exp=0", dma_wr_en); else pass++;
        dma_full = 1'b0; #1;
        chk++; if (dma_wr_en !== 1'b1) $display("FAIL rst_mid_en got=%b exp=1", dma_wr_en); else pass++;
        rst_n = 1'b0; #1;
        chk++; if (busy !== 1'b0 || {dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en} !== 4'b0000) $display("FAIL rst_mid_outs got=%b/%b exp=0/0000", busy, {dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}); else pass++;
        chk++; if (dma_wr_addr !== 64'h0 || dma_wr_data !== {DW{1'b0}} || resp_rdata !== {DW{1'b0}}) $display("FAIL rst_mid_latches got=%h exp=0", dma_wr_addr); else pass++;
        chk++; if (timeout_err !== 1'b0 || {req_ready, resp_valid} !== 4'b0000) $display("FAIL rst_mid_flags got=%b/%b exp=0/0000", timeout_err, {req_ready, resp_valid}); else pass++;
        dma_full = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req_valid = 2'b01; req_write = 2'b00; req_addr[63:0] = 64'h7000;
        dma_rd_data = LINE1; dma_empty = 1'b0; dma_rd_done = 1'b1;
        #1;
        chk++; if (req_ready !== 2'b01) $display("FAIL rst_after_ready got=%b exp=01", req_ready); else pass++;
        tick(); req_valid = 2'b00; n = 1;
        while (resp_valid == 2'b00 && n < 20) begin tick(); n++; end
        chk++; if (resp_valid !== 2'b01 || resp_rdata !== LINE1 || dma_rd_addr !== 64'h7000) $display("FAIL rst_after_resp got=%b addr=%h exp=01/7000", resp_valid, dma_rd_addr); else pass++;
        dma_empty = 1'b1; dma_rd_done = 1'b0;
        tick();
    endtask

    task automatic test_min_latency();
        req_valid = 2'b10; req_write = 2'b00; req_addr[127:64] = 64'h8000;
        dma_rd_data = LINE2; dma_empty = 1'b0;
        #1;
        chk++; if (req_ready !== 2'b10) $display("FAIL lat_ready got=%b exp=10", req_ready); else pass++;
        tick(); req_valid = 2'b00; #1;
        chk++; if (dma_rd_go !== 1'b1 || dma_rd_addr !== 64'h8000) $display("FAIL lat_go got=%b addr=%h exp=1/8000", dma_rd_go, dma_rd_addr); else pass++;
        tick(); #1;
        chk++; if (dma_rd_en !== 1'b1) $display("FAIL lat_en got=%b exp=1", dma_rd_en); else pass++;
        tick(); dma_empty = 1'b1; dma_rd_done = 1'b1; #1;
        chk++; if (resp_valid !== 2'b00) $display("FAIL lat_resp_early got=%b exp=00", resp_valid); else pass++;
        tick(); dma_rd_done = 1'b0; #1;
        chk++; if (resp_valid !== 2'b10 || resp_rdata !== LINE2) $display("FAIL lat_resp got=%b exp=10", resp_valid); else pass++;
        tick(); #1;
        chk++; if (resp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL lat_idle got=%b/%b exp=00/0", resp_valid, busy); else pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_min_latency();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
